// File: rtl/ct_pt_add_sched_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : ct_pt_add_sched_if                                               |
// | Brief   : Request/result bundle between BFV queues and the pt-add lane.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface ct_pt_add_sched_if #(
    parameter int N = 8,
    parameter int W = 16
);
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [2*N*W-1:0] req_ct_a;
    logic [2*N*W-1:0] req_ct_b;
    logic [2*N*W-1:0] req_gamma;
    logic             out_valid;
    logic             out_ready;
    logic             out_id;
    logic [N*W-1:0]   out_a;
    logic [N*W-1:0]   out_b;
    logic             busy;

    modport master (
        output req_valid, req_ct_a, req_ct_b, req_gamma, out_ready,
        input  req_ready, out_valid, out_id, out_a, out_b, busy
    );

    modport slave (
        input  req_valid, req_ct_a, req_ct_b, req_gamma, out_ready,
        output req_ready, out_valid, out_id, out_a, out_b, busy
    );
endinterface
`default_nettype wire

// File: rtl/ct_pt_add_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : ct_pt_add_sched                                                  |
// | Brief   : Two-requester round-robin front end feeding a slot-serial        |
// |           B' = (B + delta*gamma) mod q, A' = A mod q lane.                 |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ct_pt_add_sched #(
    parameter int N      = 8,
    parameter int W      = 16,
    parameter int WW     = 2*W,
    parameter int QP     = 7710,
    parameter int DELTAP = 30
) (
    input  wire logic        clk,
    input  wire logic        rst,
    ct_pt_add_sched_if.slave bus
);
    localparam int             CW       = (N > 1) ? $clog2(N) : 1;
    localparam logic [WW-1:0]  c_qp_ww  = WW'(QP);
    localparam logic [W-1:0]   c_qp_w   = W'(QP);
    localparam logic [W-1:0]   c_delta  = W'(DELTAP);
    localparam logic [CW-1:0]  c_last   = CW'(N-1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q;
    logic           last_grant_q;
    logic           out_id_q;
    logic [W-1:0]   a_q     [N];
    logic [W-1:0]   b_q     [N];
    logic [W-1:0]   g_q     [N];
    logic [W-1:0]   res_a_q [N];
    logic [W-1:0]   res_b_q [N];

    logic           w_grant;
    logic           w_accept;
    logic [1:0]     w_req_ready;
    logic           w_out_valid;
    logic           w_busy;
    logic [N*W-1:0] w_sel_a, w_sel_b, w_sel_g;

    // Tie goes to whichever requester did not win the previous grant.
    always_comb begin
        w_grant = 1'b0;
        case (bus.req_valid)
            2'b10:   w_grant = 1'b1;
            2'b11:   w_grant = ~last_grant_q;
            default: w_grant = 1'b0;
        endcase
    end

    assign w_sel_a = w_grant ? bus.req_ct_a [2*N*W-1 -: N*W] : bus.req_ct_a [N*W-1:0];
    assign w_sel_b = w_grant ? bus.req_ct_b [2*N*W-1 -: N*W] : bus.req_ct_b [N*W-1:0];
    assign w_sel_g = w_grant ? bus.req_gamma[2*N*W-1 -: N*W] : bus.req_gamma[N*W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // req_ready is masked by rst so the handshake is dead while reset is held.
    always_comb begin
        state_d     = state_q;
        w_accept    = 1'b0;
        w_req_ready = 2'b00;
        w_out_valid = 1'b0;
        w_busy      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if ((|bus.req_valid) && !rst) begin
                    w_accept    = 1'b1;
                    w_req_ready = w_grant ? 2'b10 : 2'b01;
                    state_d     = ST_RUN;
                end
            end
            ST_RUN: begin
                w_busy = 1'b1;
                if (cnt_q == c_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                w_busy      = 1'b1;
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    logic [W-1:0]  w_a_s, w_b_s, w_g_s;
    logic [WW-1:0] w_p;
    logic [W-1:0]  w_pm, w_am, w_bm, w_bres;
    logic [W:0]    w_sum;

    assign w_a_s  = a_q[cnt_q];
    assign w_b_s  = b_q[cnt_q];
    assign w_g_s  = g_q[cnt_q];
    assign w_p    = {{(WW-W){1'b0}}, w_g_s} * {{(WW-W){1'b0}}, c_delta};
    assign w_pm   = W'(w_p % c_qp_ww);
    assign w_am   = w_a_s % c_qp_w;
    assign w_bm   = w_b_s % c_qp_w;
    assign w_sum  = {1'b0, w_bm} + {1'b0, w_pm};
    assign w_bres = (w_sum >= {1'b0, c_qp_w}) ? W'(w_sum - {1'b0, c_qp_w}) : W'(w_sum);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            out_id_q     <= 1'b0;
            for (int i = 0; i < N; i++) begin
                a_q[i]     <= '0;
                b_q[i]     <= '0;
                g_q[i]     <= '0;
                res_a_q[i] <= '0;
                res_b_q[i] <= '0;
            end
        end else if (w_accept) begin
            cnt_q        <= '0;
            last_grant_q <= w_grant;
            out_id_q     <= w_grant;
            for (int i = 0; i < N; i++) begin
                a_q[i] <= w_sel_a[i*W +: W];
                b_q[i] <= w_sel_b[i*W +: W];
                g_q[i] <= w_sel_g[i*W +: W];
            end
        end else if (state_q == ST_RUN) begin
            res_a_q[cnt_q] <= w_am;
            res_b_q[cnt_q] <= w_bres;
            if (cnt_q != c_last) begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_pack
        assign bus.out_a[i*W +: W] = res_a_q[i];
        assign bus.out_b[i*W +: W] = res_b_q[i];
    end

    assign bus.req_ready = w_req_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.busy      = w_busy;
    assign bus.out_id    = out_id_q;
endmodule
`default_nettype wire

// File: tb/tb_ct_pt_add_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_ct_pt_add_sched                                               |
// | Brief   : Directed self-checking bench for ct_pt_add_sched.                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_ct_pt_add_sched;
    localparam int N = 8;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   lat;

    ct_pt_add_sched_if #(.N(N), .W(W)) bus ();

    ct_pt_add_sched #(.N(N), .W(W), .WW(2*W), .QP(7710), .DELTAP(30)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int unsigned basic_a [8] = '{1429, 4717, 6311, 3279, 7215, 6215, 6931, 973};
    int unsigned basic_b [8] = '{7531, 4381, 1094, 7529, 5909, 964, 5576, 4640};
    int unsigned basic_g [8] = '{1, 2, 3, 4, 5, 6, 7, 8};
    int unsigned basic_xb[8] = '{7561, 4441, 1184, 7649, 6059, 1144, 5786, 4880};
    int unsigned wrap_a  [8] = '{7709, 8000, 0, 65535, 7710, 1, 2, 3};
    int unsigned wrap_b  [8] = '{7700, 0, 1234, 65535, 7709, 0, 100, 7709};
    int unsigned wrap_g  [8] = '{1, 0, 257, 65535, 0, 257, 0, 1};
    int unsigned wrap_xa [8] = '{7709, 290, 0, 3855, 0, 1, 2, 3};
    int unsigned wrap_xb [8] = '{20, 0, 1234, 3855, 7709, 0, 100, 29};

    function automatic logic [127:0] pk(input int unsigned v [8]);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r[i*16 +: 16] = v[i][15:0];
        return r;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (cycles < 40) begin
            @(posedge clk);
            #1;
            cycles++;
            if (bus.out_valid) break;
        end
    endtask

    task automatic check_result(input string tag, input logic id, input int unsigned xa [8],
                                input int unsigned xb [8]);
        check({tag, "_valid"}, 128'(bus.out_valid), 128'(1));
        check({tag, "_id"},    128'(bus.out_id),    128'(id));
        check({tag, "_a"},     bus.out_a,           pk(xa));
        check({tag, "_b"},     bus.out_b,           pk(xb));
    endtask

    always @(negedge clk) begin
        check("ready_onehot0", 128'($onehot0(bus.req_ready)), 128'(1));
    end

    initial begin
        rst           = 1'b1;
        bus.out_ready = 1'b0;
        bus.req_ct_a  = {pk(wrap_a), pk(basic_a)};
        bus.req_ct_b  = {pk(wrap_b), pk(basic_b)};
        bus.req_gamma = {pk(wrap_g), pk(basic_g)};
        bus.req_valid = 2'b11;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 128'(bus.req_ready), 128'(0));
        check("rst_valid", 128'(bus.out_valid), 128'(0));
        check("rst_id",    128'(bus.out_id),    128'(0));
        check("rst_a",     bus.out_a,           128'(0));
        check("rst_b",     bus.out_b,           128'(0));
        check("rst_busy",  128'(bus.busy),      128'(0));

        // Job 1: tie from reset goes to requester 0.
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("grant1", 128'(bus.req_ready), 128'(2'b01));
        @(posedge clk);
        #1;
        bus.req_valid[0] = 1'b0;
        check("run1_busy",  128'(bus.busy),      128'(1));
        check("run1_ready", 128'(bus.req_ready), 128'(0));
        wait_done(lat);
        check("lat1", 128'(lat), 128'(N));
        check_result("job1", 1'b0, basic_a, basic_xb);

        // Back-pressure: result frozen for 5 cycles.
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check_result("hold", 1'b0, basic_a, basic_xb);
            check("hold_ready", 128'(bus.req_ready), 128'(0));
        end
        bus.req_valid[0] = 1'b1;
        bus.out_ready    = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("drop1_valid", 128'(bus.out_valid), 128'(0));
        check("drop1_busy",  128'(bus.busy),      128'(0));

        // Job 2: both valid, requester 1 was not granted last.
        @(negedge clk);
        check("grant2", 128'(bus.req_ready), 128'(2'b10));
        @(posedge clk);
        #1;
        check("run2_busy", 128'(bus.busy), 128'(1));
        wait_done(lat);
        check("lat2", 128'(lat), 128'(N));
        check_result("job2", 1'b1, wrap_xa, wrap_xb);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("drop2_valid", 128'(bus.out_valid), 128'(0));

        // Job 3: both still valid, round-robin returns to requester 0.
        @(negedge clk);
        check("grant3", 128'(bus.req_ready), 128'(2'b01));
        @(posedge clk);
        #1;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("abort_ready", 128'(bus.req_ready), 128'(0));
        check("abort_valid", 128'(bus.out_valid), 128'(0));
        check("abort_id",    128'(bus.out_id),    128'(0));
        check("abort_a",     bus.out_a,           128'(0));
        check("abort_b",     bus.out_b,           128'(0));
        check("abort_busy",  128'(bus.busy),      128'(0));
        bus.req_ct_a[127:0]  = pk(wrap_a);
        bus.req_ct_b[127:0]  = pk(wrap_b);
        bus.req_gamma[127:0] = pk(wrap_g);
        repeat (2) @(posedge clk);

        // Fresh job after reset: tie again resolves to requester 0.
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("grant4", 128'(bus.req_ready), 128'(2'b01));
        @(posedge clk);
        #1;
        bus.req_valid = 2'b00;
        wait_done(lat);
        check("lat4", 128'(lat), 128'(N));
        check_result("job4", 1'b0, wrap_xa, wrap_xb);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("drop4_valid", 128'(bus.out_valid), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
